// File: rtl/rom_dl_ctrl_if.sv
// Download bus between the HPS ioctl stream and the ROM download controller.
// Handshake: IOCTL_WR and DL_WR are single-cycle valid strobes with no ready
// or back-pressure; a byte moves on every cycle its strobe is high, and
// ADDR/DATA are only meaningful in that cycle.
// The master side drives ioctl and observes the forwarded stream and status.
// The slave side is the controller itself.
interface rom_dl_ctrl_if;
   logic        IOCTL_DOWNLOAD;
   logic [7:0]  IOCTL_INDEX;
   logic        IOCTL_WR;
   logic [24:0] IOCTL_ADDR;
   logic [7:0]  IOCTL_DATA;

   logic        DL_WR;
   logic [24:0] DL_ADDR;
   logic [7:0]  DL_DATA;
   logic        CORE_RESET;
   logic        ROM_READY;
   logic        ERR_LEN;
   logic        ERR_SEQ;
   logic [24:0] BYTE_COUNT;
   logic [15:0] CHECKSUM;

   modport master (
      output IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DATA,
      input  DL_WR, DL_ADDR, DL_DATA, CORE_RESET, ROM_READY,
      input  ERR_LEN, ERR_SEQ, BYTE_COUNT, CHECKSUM
   );

   modport slave (
      input  IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DATA,
      output DL_WR, DL_ADDR, DL_DATA, CORE_RESET, ROM_READY,
      output ERR_LEN, ERR_SEQ, BYTE_COUNT, CHECKSUM
   );
endinterface

// File: rtl/rom_dl_ctrl.sv
// ROM download front-end: filters the ioctl stream by index, re-times
// in-range writes by one register stage, tracks count/checksum/sequence and
// keeps the game core in reset until a complete, well-formed image is loaded.
module rom_dl_ctrl #(
   parameter logic [7:0]  ROM_INDEX = 8'd0,
   parameter logic [24:0] ROM_SIZE  = 25'h18500
) (
   input  logic       CLK,
   input  logic       RESET,
   rom_dl_ctrl_if.slave bus,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_READY = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   localparam logic [24:0] CNT_MAX = 25'h1FFFFFF;

   state_t      state;
   logic        q_d;
   logic        dl_wr;
   logic [24:0] dl_addr;
   logic [7:0]  dl_data;
   logic        core_reset;
   logic        rom_ready;
   logic        err_len;
   logic        err_seq;
   logic [24:0] byte_count;
   logic [15:0] checksum;

   logic        q;
   logic        start;
   logic        take;
   logic        in_range;
   logic [24:0] base_cnt;
   logic [15:0] base_sum;
   logic        base_len;
   logic        base_seq;
   logic [24:0] cnt_nxt;
   logic [15:0] sum_nxt;
   logic        len_nxt;
   logic        seq_nxt;
   logic        check_pass;

   assign q     = bus.IOCTL_DOWNLOAD & (bus.IOCTL_INDEX == ROM_INDEX);
   assign start = q & ~q_d;

   // Next-value datapath for one accepted byte; a Start cycle counts from cleared values.
   always_comb begin
      take       = 1'b0;
      in_range   = (bus.IOCTL_ADDR < ROM_SIZE);
      base_cnt   = byte_count;
      base_sum   = checksum;
      base_len   = err_len;
      base_seq   = err_seq;
      check_pass = (byte_count == ROM_SIZE) & ~err_len & ~err_seq;
      if (start) begin
         take     = bus.IOCTL_WR;
         base_cnt = '0;
         base_sum = '0;
         base_len = 1'b0;
         base_seq = 1'b0;
      end else if (state == S_LOAD) begin
         take = q & bus.IOCTL_WR;
      end
      cnt_nxt = base_cnt;
      sum_nxt = base_sum;
      len_nxt = base_len;
      seq_nxt = base_seq;
      if (take) begin
         cnt_nxt = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 25'd1;
         seq_nxt = base_seq | (bus.IOCTL_ADDR != base_cnt);
         if (in_range) begin
            sum_nxt = base_sum + {8'h00, bus.IOCTL_DATA};
         end else begin
            len_nxt = 1'b1;
         end
      end
   end

   // Control FSM with registered outputs and the forwarding register stage.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= S_IDLE;
         // Pretend the qualifier was already high so a download that is still
         // running through reset cannot produce a Start; a fresh rise is needed.
         q_d        <= 1'b1;
         dl_wr      <= 1'b0;
         dl_addr    <= '0;
         dl_data    <= '0;
         core_reset <= 1'b1;
         rom_ready  <= 1'b0;
         err_len    <= 1'b0;
         err_seq    <= 1'b0;
         byte_count <= '0;
         checksum   <= '0;
      end else begin
         q_d   <= q;
         dl_wr <= 1'b0;
         if (take && in_range) begin
            dl_wr   <= 1'b1;
            dl_addr <= bus.IOCTL_ADDR;
            dl_data <= bus.IOCTL_DATA;
         end
         if (start) begin
            // A new download rise restarts from any non-LOAD state, including
            // CHECK, so a back-to-back reload is never lost.
            state      <= S_LOAD;
            rom_ready  <= 1'b0;
            core_reset <= 1'b1;
            byte_count <= cnt_nxt;
            checksum   <= sum_nxt;
            err_len    <= len_nxt;
            err_seq    <= seq_nxt;
         end else begin
            case (state)
               S_LOAD: begin
                  if (!q) begin
                     state <= S_CHECK;
                  end else begin
                     byte_count <= cnt_nxt;
                     checksum   <= sum_nxt;
                     err_len    <= len_nxt;
                     err_seq    <= seq_nxt;
                  end
               end
               S_CHECK: begin
                  err_len    <= err_len | (byte_count != ROM_SIZE);
                  state      <= check_pass ? S_READY : S_FAIL;
                  rom_ready  <= check_pass;
                  core_reset <= ~check_pass;
               end
               default: begin
                  state <= state;
               end
            endcase
         end
      end
   end

   assign bus.DL_WR      = dl_wr;
   assign bus.DL_ADDR    = dl_addr;
   assign bus.DL_DATA    = dl_data;
   assign bus.CORE_RESET = core_reset;
   assign bus.ROM_READY  = rom_ready;
   assign bus.ERR_LEN    = err_len;
   assign bus.ERR_SEQ    = err_seq;
   assign bus.BYTE_COUNT = byte_count;
   assign bus.CHECKSUM   = checksum;
   assign dbg_state      = state;

endmodule
